// File: rtl/conv_2d_pkg.sv
// Shared types and sizing helpers for the 2-D convolution coefficient path.
package conv_2d_pkg;

  function automatic int unsigned coef_amount(input int unsigned win_size);
    return win_size * win_size;
  endfunction

  function automatic int unsigned coef_idx_w(input int unsigned win_size);
    return (win_size * win_size > 1) ? $clog2(win_size * win_size) : 1;
  endfunction

  typedef enum logic [1:0] {
    LDR_IDLE    = 2'd0,
    LDR_PENDING = 2'd1,
    LDR_LOAD    = 2'd2
  } conv_2d_loader_state_t;

endpackage

// File: rtl/conv_2d_if.sv
// Coefficient write port into the convolution core: one indexed write per strobe.
interface conv_2d_if #(
  parameter int unsigned COEF_WIDTH = 13,
  parameter int unsigned WIN_SIZE   = 3
);
  import conv_2d_pkg::*;

  localparam int unsigned IDX_W = coef_idx_w(WIN_SIZE);

  logic                  wr_stb;
  logic [IDX_W-1:0]      coef_num;
  logic [COEF_WIDTH-1:0] coef_val;

  modport master (output wr_stb, output coef_num, output coef_val);
  modport slave  (input  wr_stb, input  coef_num, input  coef_val);

endinterface

// File: rtl/conv_2d_frame_mon.sv
// Passive AXI4-Stream video monitor: counts lines and flags the last beat of a frame.
module conv_2d_frame_mon #(
  parameter int unsigned FRAME_RES_Y = 1080
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic vid_tvalid_i,
  input  logic vid_tready_i,
  input  logic vid_tlast_i,
  input  logic vid_tuser_i,
  output logic eof_c_o
);

  localparam int unsigned LINE_W = (FRAME_RES_Y > 1) ? $clog2(FRAME_RES_Y) : 1;
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(FRAME_RES_Y - 1);

  logic [LINE_W-1:0] r_line_cnt;
  logic              w_beat;
  logic              w_last_line;

  assign w_beat      = vid_tvalid_i & vid_tready_i;
  assign w_last_line = (r_line_cnt == LAST_LINE);
  assign eof_c_o     = w_beat & vid_tlast_i & w_last_line;

  // Start-of-frame resynchronises the count even if a line was lost upstream.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_line_cnt <= '0;
    end else if (w_beat & vid_tuser_i) begin
      r_line_cnt <= '0;
    end else if (w_beat & vid_tlast_i) begin
      r_line_cnt <= w_last_line ? '0 : r_line_cnt + LINE_W'(1);
    end
  end

endmodule

// File: rtl/conv_2d_coef_loader.sv
// CSR shadow bank for convolution coefficients; replays a full kernel snapshot
// onto the core's write port, optionally aligned to a video frame boundary.
module conv_2d_coef_loader
  import conv_2d_pkg::*;
#(
  parameter int unsigned  COEF_WIDTH  = 13,
  parameter int unsigned  WIN_SIZE    = 3,
  parameter int unsigned  FRAME_RES_Y = 1080,
  parameter bit           LOAD_ON_EOF = 1'b1,
  localparam int unsigned IDX_W       = coef_idx_w(WIN_SIZE)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  csr_wr_i,
  input  logic [IDX_W-1:0]      csr_addr_i,
  input  logic [COEF_WIDTH-1:0] csr_data_i,
  input  logic                  commit_i,
  input  logic                  vid_tvalid_i,
  input  logic                  vid_tready_i,
  input  logic                  vid_tlast_i,
  input  logic                  vid_tuser_i,
  conv_2d_if.master             conv_2d_ctrl_o,
  output logic                  pending_o,
  output logic                  busy_o
);

  localparam int unsigned        COEF_AMOUNT = coef_amount(WIN_SIZE);
  localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(COEF_AMOUNT - 1);

  conv_2d_loader_state_t r_state;
  conv_2d_loader_state_t w_state_nxt;
  conv_2d_loader_state_t w_start_state;

  logic [COEF_WIDTH-1:0] r_shadow [COEF_AMOUNT];
  logic [COEF_WIDTH-1:0] r_snap   [COEF_AMOUNT];
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic                  r_commit_q;
  logic                  w_commit_q_nxt;
  logic                  w_load_entry;
  logic                  w_eof;

  logic                  r_wr_stb;
  logic [IDX_W-1:0]      r_coef_num;
  logic [COEF_WIDTH-1:0] r_coef_val;
  logic                  r_pending;
  logic                  r_busy;

  conv_2d_frame_mon #(
    .FRAME_RES_Y (FRAME_RES_Y)
  ) u_frame_mon (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .vid_tvalid_i (vid_tvalid_i),
    .vid_tready_i (vid_tready_i),
    .vid_tlast_i  (vid_tlast_i),
    .vid_tuser_i  (vid_tuser_i),
    .eof_c_o      (w_eof)
  );

  assign w_start_state = LOAD_ON_EOF ? LDR_PENDING : LDR_LOAD;

  // Next state; eof is ignored in IDLE so a same-cycle commit waits a full frame.
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_commit_q_nxt = r_commit_q;
    w_load_entry   = 1'b0;
    case (r_state)
      LDR_IDLE: begin
        if (commit_i) begin
          w_state_nxt  = w_start_state;
          w_load_entry = !LOAD_ON_EOF;
        end
      end
      LDR_PENDING: begin
        if (w_eof) begin
          w_state_nxt  = LDR_LOAD;
          w_load_entry = 1'b1;
        end
      end
      LDR_LOAD: begin
        w_idx_nxt = r_idx + IDX_W'(1);
        if (commit_i) begin
          w_commit_q_nxt = 1'b1;
        end
        if (r_idx == LAST_IDX) begin
          w_commit_q_nxt = 1'b0;
          if (r_commit_q | commit_i) begin
            w_state_nxt  = w_start_state;
            w_load_entry = !LOAD_ON_EOF;
          end else begin
            w_state_nxt = LDR_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = LDR_IDLE;
      end
    endcase
    if (w_load_entry) begin
      w_idx_nxt = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= LDR_IDLE;
      r_idx      <= '0;
      r_commit_q <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_commit_q <= w_commit_q_nxt;
    end
  end

  // Snapshot reads the pre-edge shadow, so a CSR write in the entry cycle is excluded.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(COEF_AMOUNT); i++) begin
        r_shadow[i] <= '0;
        r_snap[i]   <= '0;
      end
    end else begin
      if (csr_wr_i && (32'(csr_addr_i) < COEF_AMOUNT)) begin
        r_shadow[csr_addr_i] <= csr_data_i;
      end
      if (w_load_entry) begin
        for (int i = 0; i < int'(COEF_AMOUNT); i++) begin
          r_snap[i] <= r_shadow[i];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_stb   <= 1'b0;
      r_coef_num <= '0;
      r_coef_val <= '0;
      r_pending  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_wr_stb  <= (r_state == LDR_LOAD);
      r_pending <= (w_state_nxt == LDR_PENDING);
      r_busy    <= (w_state_nxt == LDR_LOAD);
      if (r_state == LDR_LOAD) begin
        r_coef_num <= r_idx;
        r_coef_val <= r_snap[r_idx];
      end
    end
  end

  assign conv_2d_ctrl_o.wr_stb   = r_wr_stb;
  assign conv_2d_ctrl_o.coef_num = r_coef_num;
  assign conv_2d_ctrl_o.coef_val = r_coef_val;
  assign pending_o               = r_pending;
  assign busy_o                  = r_busy;

endmodule

// File: tb/tb_conv_2d_coef_loader.sv
// Scoreboard bench: one immediate-load instance and one end-of-frame instance (4-line frames).
module tb_conv_2d_coef_loader;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  num;
    logic [12:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;

  logic        csr_wr0 = 0, commit0 = 0, tvalid0 = 0, tready0 = 0, tlast0 = 0, tuser0 = 0;
  logic [3:0]  csr_addr0 = '0;
  logic [12:0] csr_data0 = '0;
  logic        pending0, busy0;

  logic        csr_wr1 = 0, commit1 = 0, tvalid1 = 0, tready1 = 0, tlast1 = 0, tuser1 = 0;
  logic [3:0]  csr_addr1 = '0;
  logic [12:0] csr_data1 = '0;
  logic        pending1, busy1;

  conv_2d_if #(.COEF_WIDTH(13), .WIN_SIZE(3)) if0 ();
  conv_2d_if #(.COEF_WIDTH(13), .WIN_SIZE(3)) if1 ();

  conv_2d_coef_loader #(.COEF_WIDTH(13), .WIN_SIZE(3), .FRAME_RES_Y(4), .LOAD_ON_EOF(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .csr_wr_i(csr_wr0), .csr_addr_i(csr_addr0), .csr_data_i(csr_data0),
    .commit_i(commit0), .vid_tvalid_i(tvalid0), .vid_tready_i(tready0), .vid_tlast_i(tlast0),
    .vid_tuser_i(tuser0), .conv_2d_ctrl_o(if0), .pending_o(pending0), .busy_o(busy0));

  conv_2d_coef_loader #(.COEF_WIDTH(13), .WIN_SIZE(3), .FRAME_RES_Y(4), .LOAD_ON_EOF(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .csr_wr_i(csr_wr1), .csr_addr_i(csr_addr1), .csr_data_i(csr_data1),
    .commit_i(commit1), .vid_tvalid_i(tvalid1), .vid_tready_i(tready1), .vid_tlast_i(tlast1),
    .vid_tuser_i(tuser1), .conv_2d_ctrl_o(if1), .pending_o(pending1), .busy_o(busy1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  logic [12:0] sh0 [9];
  logic [12:0] sh1 [9];
  int busy_cnt0 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_upload(input int d, input int unsigned base);
    for (int i = 0; i < 9; i++) begin
      if (d == 0) q0.push_back('{cyc: base + i, num: 4'(i), val: sh0[i]});
      else        q1.push_back('{cyc: base + i, num: 4'(i), val: sh1[i]});
    end
  endtask

  // CSR write, optionally with a commit in the same cycle (immediate-load instance only).
  task automatic csr_write(input int d, input logic [3:0] a, input logic [12:0] v, input bit with_commit);
    if (d == 0) begin
      csr_wr0 = 1; csr_addr0 = a; csr_data0 = v; commit0 = with_commit;
      if (with_commit) push_upload(0, cyc + 2);
      if (a < 9) sh0[a] = v;
    end else begin
      csr_wr1 = 1; csr_addr1 = a; csr_data1 = v; commit1 = with_commit;
      if (a < 9) sh1[a] = v;
    end
    step();
    csr_wr0 = 0; commit0 = 0; csr_wr1 = 0; commit1 = 0;
  endtask

  task automatic commit_now(input int d, input bit expect_upload);
    if (d == 0) begin
      commit0 = 1;
      if (expect_upload) push_upload(0, cyc + 2);
    end else begin
      commit1 = 1;
    end
    step();
    commit0 = 0; commit1 = 0;
  endtask

  // One video cycle on the end-of-frame instance; push=1 marks the eof beat.
  task automatic vid1(input bit v, input bit r, input bit l, input bit u, input bit c, input bit push);
    tvalid1 = v; tready1 = r; tlast1 = l; tuser1 = u; commit1 = c;
    if (push) push_upload(1, cyc + 2);
    step();
    tvalid1 = 0; tready1 = 0; tlast1 = 0; tuser1 = 0; commit1 = 0;
  endtask

  task automatic lines1(input int n);
    for (int i = 0; i < n; i++) vid1(1, 1, 1, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (busy0) busy_cnt0++;
    if (if0.wr_stb) begin
      if (q0.size() == 0) check("stb0_unexpected", 32'd1, 32'd0);
      else begin
        e0 = q0.pop_front();
        check("stb0_cyc", 32'(cyc), 32'(e0.cyc));
        check("stb0_num", 32'(if0.coef_num), 32'(e0.num));
        check("stb0_val", 32'(if0.coef_val), 32'(e0.val));
      end
    end
    if (if1.wr_stb) begin
      if (q1.size() == 0) check("stb1_unexpected", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        check("stb1_cyc", 32'(cyc), 32'(e1.cyc));
        check("stb1_num", 32'(if1.coef_num), 32'(e1.num));
        check("stb1_val", 32'(if1.coef_val), 32'(e1.val));
      end
    end
  end

  initial begin
    for (int i = 0; i < 9; i++) begin sh0[i] = '0; sh1[i] = '0; end
    wait_cyc(3);
    rst = 0;
    step();
    check("rst_stb0",  32'(if0.wr_stb),   32'd0);
    check("rst_num0",  32'(if0.coef_num), 32'd0);
    check("rst_val0",  32'(if0.coef_val), 32'd0);
    check("rst_pend0", 32'(pending0),     32'd0);
    check("rst_busy0", 32'(busy0),        32'd0);
    check("rst_pend1", 32'(pending1),     32'd0);
    check("rst_busy1", 32'(busy1),        32'd0);

    // Immediate load: shadow 1..9, commit, 9 writes starting 2 cycles later.
    for (int i = 0; i < 9; i++) csr_write(0, 4'(i), 13'(i + 1), 0);
    busy_cnt0 = 0;
    commit_now(0, 1);
    wait_cyc(12);
    check("busy0_len",  32'(busy_cnt0),   32'd9);
    check("q0_drained", 32'(q0.size()),   32'd0);
    check("stb0_idle",  32'(if0.wr_stb),  32'd0);

    // Out-of-range write ignored; write in the load-entry cycle misses the snapshot.
    csr_write(0, 4'd9, 13'h0AA, 0);
    csr_write(0, 4'd4, 13'h1FFF, 1);
    wait_cyc(12);
    commit_now(0, 1);
    wait_cyc(12);
    check("q0_drained2", 32'(q0.size()), 32'd0);

    // End-of-frame instance: commit mid-frame waits for the 4th counted tlast.
    for (int i = 0; i < 9; i++) csr_write(1, 4'(i), 13'(13'h100 + i), 0);
    vid1(1, 1, 0, 1, 0, 0);
    vid1(1, 1, 1, 0, 0, 0);
    commit_now(1, 0);
    check("pend1_set",  32'(pending1), 32'd1);
    check("busy1_wait", 32'(busy1),    32'd0);
    lines1(2);
    vid1(1, 0, 1, 0, 0, 0);
    wait_cyc(3);
    check("pend1_stall", 32'(pending1), 32'd1);
    vid1(1, 1, 1, 0, 0, 1);
    check("busy1_load", 32'(busy1),    32'd1);
    check("pend1_clr",  32'(pending1), 32'd0);
    wait_cyc(12);
    check("q1_drained", 32'(q1.size()), 32'd0);

    // Commit during upload re-arms; extra commit while pending adds nothing.
    commit_now(1, 0);
    lines1(3);
    vid1(1, 1, 1, 0, 0, 1);
    wait_cyc(2);
    commit_now(1, 0);
    wait_cyc(10);
    check("pend1_rearm", 32'(pending1), 32'd1);
    commit_now(1, 0);
    csr_write(1, 4'd0, 13'h0777, 0);
    lines1(3);
    vid1(1, 1, 1, 0, 0, 1);
    wait_cyc(14);
    check("q1_drained2", 32'(q1.size()), 32'd0);
    check("pend1_done",  32'(pending1),  32'd0);

    // Commit coinciding with eof while idle waits for the following frame.
    lines1(3);
    vid1(1, 1, 1, 0, 1, 0);
    check("pend1_same", 32'(pending1), 32'd1);
    lines1(3);
    vid1(1, 1, 1, 0, 0, 1);
    wait_cyc(12);
    check("q1_drained3", 32'(q1.size()), 32'd0);

    // Reset in the middle of an upload.
    commit0 = 1;
    for (int i = 0; i < 4; i++) q0.push_back('{cyc: cyc + 2 + i, num: 4'(i), val: sh0[i]});
    step();
    commit0 = 0;
    wait_cyc(5);
    check("stb0_5th",  32'(if0.wr_stb),   32'd1);
    check("num0_5th",  32'(if0.coef_num), 32'd4);
    rst = 1;
    #1;
    check("arst_stb0",  32'(if0.wr_stb),   32'd0);
    check("arst_num0",  32'(if0.coef_num), 32'd0);
    check("arst_val0",  32'(if0.coef_val), 32'd0);
    check("arst_busy0", 32'(busy0),        32'd0);
    check("arst_pend0", 32'(pending0),     32'd0);
    wait_cyc(2);
    rst = 0;
    for (int i = 0; i < 9; i++) begin sh0[i] = '0; sh1[i] = '0; end
    step();
    check("q0_after_rst", 32'(q0.size()), 32'd0);
    csr_write(0, 4'd2, 13'h0123, 0);
    commit_now(0, 1);
    wait_cyc(12);
    check("q0_drained3", 32'(q0.size()), 32'd0);
    check("q1_final",    32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
